// File: rtl/regfile_wb_arbiter.sv
// Merges scalar-pipeline and vector-coprocessor writebacks onto the single register-file write port; optional WB_BYPASS_EN.
// Latency: scalar 1 cycle; coprocessor 2 cycles via FIFO (1 cycle via bypass when WB_BYPASS_EN is defined).
// Backpressure: scalar never stalls; vx_ready drops when the FIFO is full, on flush, or when vx_addr already has a pending write.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sc_wb_en,
    input  logic [ADDR_W-1:0]            sc_wb_addr,
    input  logic [DATA_W-1:0]            sc_wb_data,
    input  logic                         vx_valid,
    output logic                         vx_ready,
    input  logic [ADDR_W-1:0]            vx_addr,
    input  logic [DATA_W-1:0]            vx_data,
    input  logic                         flush,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            dest_addr,
    output logic [DATA_W-1:0]            wr_data,
    output logic [(1<<ADDR_W)-1:0]       pending_mask,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         waw_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]      q_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]      q_data [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr, wr_ptr;
    logic                   full, empty, sc_take, accept, push, pop, bypass;
    logic [(1<<ADDR_W)-1:0] mask_n;

    always_comb begin
        sc_take  = sc_wb_en && (sc_wb_addr != '0);
        full     = (fifo_count == CNT_W'(FIFO_DEPTH));
        empty    = (fifo_count == '0);
        vx_ready = !full && !flush && !pending_mask[vx_addr];
        accept   = vx_valid && vx_ready && (vx_addr != '0);
        // Scalar write to x0 is an idle slot, so the FIFO can drain then.
        pop      = !sc_take && !empty && !flush;
`ifdef WB_BYPASS_EN
        bypass   = accept && empty && !sc_take;
`else
        bypass   = 1'b0;
`endif
        push     = accept && !bypass;
    end

    // Clear after set so a retiring entry always wins over a same-edge set.
    always_comb begin
        mask_n = pending_mask;
        if (push)  mask_n[vx_addr] = 1'b1;
        if (pop)   mask_n[q_addr[rd_ptr]] = 1'b0;
        if (flush) mask_n = '0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= vx_addr;
            q_data[wr_ptr] <= vx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en        <= 1'b0;
            dest_addr    <= '0;
            wr_data      <= '0;
            pending_mask <= '0;
            fifo_count   <= '0;
            waw_err      <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
        end else begin
            pending_mask <= mask_n;
            waw_err      <= waw_err | (sc_take && pending_mask[sc_wb_addr]);
            wr_en        <= sc_take | pop | bypass;
            if (sc_take) begin
                dest_addr <= sc_wb_addr;
                wr_data   <= sc_wb_data;
            end else if (pop) begin
                dest_addr <= q_addr[rd_ptr];
                wr_data   <= q_data[rd_ptr];
            end else if (bypass) begin
                dest_addr <= vx_addr;
                wr_data   <= vx_data;
            end
            if (flush) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end
endmodule
